// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared constants for the immediate-extension arbiter slice:
//               extension mode encodings, default widths, requester IDs.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

    // Default widths for the immediate and the extended result
    localparam int IMM_W_DEF  = 16;
    localparam int DATA_W_DEF = 32;

    // Extension mode encodings
    localparam logic [1:0] EXT_SIGN   = 2'b00;
    localparam logic [1:0] EXT_ZERO   = 2'b01;
    localparam logic [1:0] EXT_UPPER  = 2'b10;
    localparam logic [1:0] EXT_BRANCH = 2'b11;

    // Requester identifiers as carried on out_id
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_BR  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Purely combinational mode-selected immediate extender.
//               Sign/zero extension, upper-load placement and branch-offset
//               (sign-extend then shift left by two).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IMM_W  = IMM_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [IMM_W-1:0]  i_imm,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_sext;

    // Sign-extended view is shared by the sign and branch modes
    assign w_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};

    // Select the extension; branch mode drops the top two sign bits
    always_comb begin
        o_data = w_sext;
        case (i_mode)
            EXT_SIGN:  o_data = w_sext;
            EXT_ZERO:  o_data = {{(DATA_W-IMM_W){1'b0}}, i_imm};
            EXT_UPPER: o_data = {i_imm, {(DATA_W-IMM_W){1'b0}}};
            default:   o_data = {w_sext[DATA_W-3:0], 2'b00};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_arbiter
// Description : Round-robin arbiter sharing one immediate extender between
//               the decode/ALU path (req0) and the branch-offset path (req1).
//               Result is held in a single output register with valid/ready
//               backpressure; back-to-back transfers without bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_arbiter
    import imm_ext_pkg::*;
#(
    parameter int IMM_W   = IMM_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RR_INIT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [IMM_W-1:0]  req0_imm,
    input  logic [1:0]        req0_mode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [IMM_W-1:0]  req1_imm,
    input  logic [1:0]        req1_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id
);

    // Output register occupancy
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // Requester that must win the first contention after reset
    localparam logic c_rr_first = (RR_INIT == 0) ? REQ_ALU : REQ_BR;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_id;
    logic              r_last;      // requester granted most recently

    logic              w_can_load;
    logic              w_sel;
    logic              w_grant;
    logic [IMM_W-1:0]  w_imm;
    logic [1:0]        w_mode;
    logic [DATA_W-1:0] w_ext;

    // Arbitration: lone requester wins; on contention the one not granted last wins
    always_comb begin
        w_can_load = (r_state == ST_EMPTY) | out_ready;
        w_sel      = REQ_ALU;
        if (req0_valid & req1_valid) begin
            w_sel = ~r_last;
        end else if (req1_valid) begin
            w_sel = REQ_BR;
        end
        w_grant = w_can_load & (req0_valid | req1_valid);
    end

    assign req0_ready = w_grant & (w_sel == REQ_ALU);
    assign req1_ready = w_grant & (w_sel == REQ_BR);

    // Single shared extender sits after the grant mux
    assign w_imm  = (w_sel == REQ_BR) ? req1_imm  : req0_imm;
    assign w_mode = (w_sel == REQ_BR) ? req1_mode : req0_mode;

    imm_ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .i_imm  (w_imm),
        .i_mode (w_mode),
        .o_data (w_ext)
    );

    // Occupancy state register; reset discards any held result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next occupancy: a grant always fills, a drain without grant empties
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_grant) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_grant)        w_state_nxt = ST_FULL;
                else if (out_ready) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Result, source ID and round-robin pointer load only on an actual grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data <= '0;
            r_out_id   <= REQ_ALU;
            r_last     <= ~c_rr_first;
        end else if (w_grant) begin
            r_out_data <= w_ext;
            r_out_id   <= w_sel;
            r_last     <= w_sel;
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_arbiter
// Description : Self-checking bench for imm_ext_arbiter. A predictor models
//               arbitration and output occupancy and queues expected results;
//               a monitor pops and compares whatever the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [15:0] req0_imm, req1_imm;
    logic [1:0]  req0_mode, req1_mode;
    logic        out_valid, out_ready, out_id;
    logic [31:0] out_data;

    imm_ext_arbiter #(.IMM_W(16), .DATA_W(32), .RR_INIT(0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_imm   (req0_imm),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_imm   (req1_imm),
        .req1_mode  (req1_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        id;
    } item_t;

    item_t q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    logic  m_full;
    logic  m_last;
    logic  a0, a1;

    logic [31:0] mode_exp [4] = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%08h required=%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference extension from the mode definitions, using plain arithmetic
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] mode);
        int s;
        s = int'($signed(imm));
        case (mode)
            2'd0:    return 32'(s);
            2'd1:    return 32'(imm);
            2'd2:    return 32'(imm) << 16;
            default: return 32'(s * 4);
        endcase
    endfunction

    // Predictor: expected readies and occupancy, queues the expected result of each grant
    always @(negedge clk) begin : predictor
        logic can_load, grant, sel;
        if (!reset_n) begin
            q.delete();
            m_full = 1'b0;
            m_last = 1'b1;
        end else begin
            chk("out_valid", 32'(out_valid), 32'(m_full));
            can_load = !m_full || out_ready;
            grant    = can_load && (req0_valid || req1_valid);
            sel      = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("req0_ready", 32'(req0_ready), 32'(grant && !sel));
            chk("req1_ready", 32'(req1_ready), 32'(grant && sel));
            if (grant) begin
                q.push_back(item_t'{sel ? ref_ext(req1_imm, req1_mode) : ref_ext(req0_imm, req0_mode), sel});
                m_last = sel;
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compare the presented result with the oldest expected one
    always @(negedge clk) begin : monitor
        if (reset_n && out_valid) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out_unexpected: actual=valid data %08h required=no output", out_data);
            end else begin
                chk("out_data", out_data, q[0].data);
                chk("out_id", 32'(out_id), 32'(q[0].id));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(negedge clk);
        a0 = req0_valid && req0_ready;
        a1 = req1_valid && req1_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req0_valid = 1'b0; req0_imm = '0; req0_mode = '0;
        req1_valid = 1'b0; req1_imm = '0; req1_mode = '0;
        out_ready  = 1'b1;
        a0 = 1'b0; a1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_req0_ready", 32'(req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(req1_ready), 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: alternate starting with requester 0
        req0_valid = 1'b1; req0_imm = 16'h0001; req0_mode = 2'b00;
        req1_valid = 1'b1; req1_imm = 16'hFFFF; req1_mode = 2'b11;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rr_id", 32'(out_id), 32'(i % 2));
            chk("rr_data", out_data, (i % 2 == 1) ? 32'hFFFFFFFC : 32'h00000001);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // All four modes from requester 0
        for (int m = 0; m < 4; m++) begin
            req0_valid = 1'b1; req0_imm = 16'h8001; req0_mode = 2'(m);
            step();
            chk("mode_data", out_data, mode_exp[m]);
            chk("mode_id", 32'(out_id), 32'd0);
        end
        req0_valid = 1'b0;

        // Backpressure then no-bubble handover to a waiting requester 1
        req0_valid = 1'b1; req0_imm = 16'h1234; req0_mode = 2'b10;
        step();
        chk("bp_load", out_data, 32'h12340000);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_imm = 16'h7FFF; req1_mode = 2'b00;
        out_ready  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold", out_data, 32'h12340000);
            chk("bp_req1_ready", 32'(req1_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next_data", out_data, 32'h00007FFF);
        chk("bp_next_id", 32'(out_id), 32'd1);
        req1_valid = 1'b0;

        // Drain to empty
        req0_valid = 1'b1; req0_imm = 16'h0042; req0_mode = 2'b01;
        step();
        req0_valid = 1'b0;
        chk("drain_full", 32'(out_valid), 32'd1);
        step();
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Asynchronous reset while holding a result
        req0_valid = 1'b1; req0_imm = 16'h8001; req0_mode = 2'b00;
        step();
        req0_valid = 1'b0; out_ready = 1'b0;
        step();
        chk("pre_rst_hold", out_data, 32'hFFFF8001);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_data", out_data, 32'd0);
        req0_valid = 1'b1; req0_imm = 16'h0005; req0_mode = 2'b01;
        req1_valid = 1'b1; req1_imm = 16'h0006; req1_mode = 2'b01;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        step();
        chk("post_rst_id", 32'(out_id), 32'd0);
        chk("post_rst_data", out_data, 32'h00000005);
        step();
        chk("post_rst_id2", 32'(out_id), 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomised traffic; a requester holds its request until accepted
        a0 = 1'b0; a1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid || a0) begin
                req0_valid = ($urandom_range(0, 99) < 60);
                req0_imm   = 16'($urandom);
                req0_mode  = 2'($urandom);
            end
            if (!req1_valid || a1) begin
                req1_valid = ($urandom_range(0, 99) < 60);
                req1_imm   = 16'($urandom);
                req1_mode  = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 99) < 70);
            step();
        end

        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
